// File: rtl/cond_status_unit.sv
// NZCV status register with zero-bubble flag forwarding and ARM condition evaluation.
// The verdict for the ID instruction is registered into the ID/EX boundary.
module cond_status_unit #(
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              s_in,
  input  logic              ex_valid_in,
  input  logic [3:0]        cond_in,
  input  logic              id_valid_in,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic              cond_pass_out,
  output logic              cond_valid_out,
  output logic [FLAG_W-1:0] flags_out,
  output logic              carry_out
);

  // Flag bit order: [3]=V, [2]=C, [1]=Z, [0]=N
  function automatic logic cond_decode(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[0];
    z = f[1];
    c = f[2];
    v = f[3];
    case (cond)
      4'b0000: cond_decode = z;
      4'b0001: cond_decode = ~z;
      4'b0010: cond_decode = c;
      4'b0011: cond_decode = ~c;
      4'b0100: cond_decode = n;
      4'b0101: cond_decode = ~n;
      4'b0110: cond_decode = v;
      4'b0111: cond_decode = ~v;
      4'b1000: cond_decode = c & ~z;
      4'b1001: cond_decode = ~c | z;
      4'b1010: cond_decode = (n == v);
      4'b1011: cond_decode = (n != v);
      4'b1100: cond_decode = ~z & (n == v);
      4'b1101: cond_decode = z | (n != v);
      4'b1110: cond_decode = 1'b1;
      4'b1111: cond_decode = 1'b0;
      default: cond_decode = 1'b0;
    endcase
  endfunction

  logic [FLAG_W-1:0] nzcv_d, nzcv_q;
  logic [FLAG_W-1:0] eff_s;
  logic              flag_wr_s;
  logic              cond_pass_d, cond_pass_q;
  logic              cond_valid_d, cond_valid_q;

  assign flag_wr_s = ex_valid_in & s_in;

  // Status register next value and forwarded flags seen by ID
  always_comb begin
    nzcv_d = nzcv_q;
    eff_s  = nzcv_q;
    if (flag_wr_s) begin
      nzcv_d = flags_in;
      eff_s  = flags_in;
    end else begin
      nzcv_d = nzcv_q;
      eff_s  = nzcv_q;
    end
  end

  // ID/EX verdict: flush beats stall; pass is always qualified by valid
  always_comb begin
    cond_pass_d  = cond_pass_q;
    cond_valid_d = cond_valid_q;
    if (flush_in) begin
      cond_pass_d  = 1'b0;
      cond_valid_d = 1'b0;
    end else if (stall_in) begin
      cond_pass_d  = cond_pass_q;
      cond_valid_d = cond_valid_q;
    end else begin
      cond_valid_d = id_valid_in;
      cond_pass_d  = id_valid_in & cond_decode(cond_in, eff_s);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nzcv_q       <= {FLAG_W{1'b0}};
      cond_pass_q  <= 1'b0;
      cond_valid_q <= 1'b0;
    end else begin
      nzcv_q       <= nzcv_d;
      cond_pass_q  <= cond_pass_d;
      cond_valid_q <= cond_valid_d;
    end
  end

  assign flags_out      = nzcv_q;
  assign carry_out      = nzcv_q[2];
  assign cond_pass_out  = cond_pass_q;
  assign cond_valid_out = cond_valid_q;

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed, table-driven bench for cond_status_unit with a full decode sweep
// and hand-written reset/stall/flush sequences.
module tb_cond_status_unit;

  logic       clk;
  logic       reset_n;
  logic [3:0] flags_in;
  logic       s_in;
  logic       ex_valid_in;
  logic [3:0] cond_in;
  logic       id_valid_in;
  logic       stall_in;
  logic       flush_in;
  logic       cond_pass_out;
  logic       cond_valid_out;
  logic [3:0] flags_out;
  logic       carry_out;

  int n_checks = 0;
  int n_fail   = 0;

  cond_status_unit #(.FLAG_W(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flags_in       (flags_in),
    .s_in           (s_in),
    .ex_valid_in    (ex_valid_in),
    .cond_in        (cond_in),
    .id_valid_in    (id_valid_in),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .cond_pass_out  (cond_pass_out),
    .cond_valid_out (cond_valid_out),
    .flags_out      (flags_out),
    .carry_out      (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic       s;
    logic       exv;
    logic [3:0] cond;
    logic       idv;
    logic       stall;
    logic       flush;
    logic       exp_pass;
    logic       exp_valid;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: even codes give a base condition, odd codes invert it.
  function automatic logic ref_decode(input logic [3:0] c, input logic [3:0] f);
    logic base;
    logic nf, zf, cf, vf;
    nf = f[0]; zf = f[1]; cf = f[2]; vf = f[3];
    if (c[3:1] == 3'd0)      base = zf;
    else if (c[3:1] == 3'd1) base = cf;
    else if (c[3:1] == 3'd2) base = nf;
    else if (c[3:1] == 3'd3) base = vf;
    else if (c[3:1] == 3'd4) base = cf && !zf;
    else if (c[3:1] == 3'd5) base = (nf ~^ vf);
    else if (c[3:1] == 3'd6) base = !zf && (nf ~^ vf);
    else                     base = 1'b1;
    return c[0] ? !base : base;
  endfunction

  task automatic drive(input vec_t v);
    flags_in    = v.flags;
    s_in        = v.s;
    ex_valid_in = v.exv;
    cond_in     = v.cond;
    id_valid_in = v.idv;
    stall_in    = v.stall;
    flush_in    = v.flush;
  endtask

  task automatic set_idle();
    flags_in = 4'h0; s_in = 1'b0; ex_valid_in = 1'b0;
    cond_in = 4'h0; id_valid_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
  endtask

  task automatic step_check(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check({name, ".pass"},  {3'b000, cond_pass_out},  {3'b000, v.exp_pass});
    check({name, ".valid"}, {3'b000, cond_valid_out}, {3'b000, v.exp_valid});
    check({name, ".flags"}, flags_out, v.exp_flags);
    check({name, ".carry"}, {3'b000, carry_out}, {3'b000, v.exp_flags[2]});
  endtask

  initial begin
    //          flags   s     exv   cond    idv   stall flush pass  valid flags
    tbl[0]  = '{4'b0010,1'b1,1'b1,4'b0000,1'b1,1'b0,1'b0,1'b1,1'b1,4'b0010}; // EQ fwd
    tbl[1]  = '{4'b0010,1'b1,1'b1,4'b0001,1'b1,1'b0,1'b0,1'b0,1'b1,4'b0010}; // NE fwd
    tbl[2]  = '{4'b1001,1'b1,1'b1,4'b1010,1'b1,1'b0,1'b0,1'b1,1'b1,4'b1001}; // GE
    tbl[3]  = '{4'b0000,1'b0,1'b0,4'b1011,1'b1,1'b0,1'b0,1'b0,1'b1,4'b1001}; // LT
    tbl[4]  = '{4'b0100,1'b1,1'b1,4'b1000,1'b1,1'b0,1'b0,1'b1,1'b1,4'b0100}; // HI
    tbl[5]  = '{4'b0000,1'b0,1'b1,4'b0010,1'b1,1'b0,1'b0,1'b1,1'b1,4'b0100}; // no S
    tbl[6]  = '{4'b1111,1'b1,1'b0,4'b0000,1'b1,1'b0,1'b0,1'b0,1'b1,4'b0100}; // S w/o valid
    tbl[7]  = '{4'b0000,1'b0,1'b0,4'b1111,1'b1,1'b0,1'b0,1'b0,1'b1,4'b0100}; // NV
    tbl[8]  = '{4'b0000,1'b0,1'b0,4'b1110,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0100}; // id invalid
    tbl[9]  = '{4'b0000,1'b0,1'b0,4'b1110,1'b1,1'b0,1'b0,1'b1,1'b1,4'b0100}; // AL
    tbl[10] = '{4'b0001,1'b1,1'b1,4'b1111,1'b1,1'b1,1'b0,1'b1,1'b1,4'b0001}; // stall+write
    tbl[11] = '{4'b0000,1'b0,1'b0,4'b0000,1'b1,1'b1,1'b0,1'b1,1'b1,4'b0001}; // stall
    tbl[12] = '{4'b0000,1'b0,1'b0,4'b0101,1'b1,1'b1,1'b0,1'b1,1'b1,4'b0001}; // stall
    tbl[13] = '{4'b0000,1'b0,1'b0,4'b1110,1'b1,1'b1,1'b1,1'b0,1'b0,4'b0001}; // flush+stall
    tbl[14] = '{4'b1000,1'b1,1'b1,4'b1110,1'b1,1'b0,1'b1,1'b0,1'b0,4'b1000}; // flush+write
    tbl[15] = '{4'b0000,1'b0,1'b0,4'b1101,1'b1,1'b0,1'b0,1'b1,1'b1,4'b1000}; // LE (N=0,V=1)

    // Reset held with an active flag write on the inputs
    reset_n = 1'b0;
    flags_in = 4'hF; s_in = 1'b1; ex_valid_in = 1'b1;
    cond_in = 4'b1110; id_valid_in = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst.flags", flags_out, 4'h0);
      check("rst.carry", {3'b000, carry_out}, 4'h0);
      check("rst.valid", {3'b000, cond_valid_out}, 4'h0);
      check("rst.pass",  {3'b000, cond_pass_out}, 4'h0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    set_idle();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) step_check($sformatf("tbl%0d", i), tbl[i]);

    // Full decode sweep: load each flag value, then evaluate every condition
    for (int f = 0; f < 16; f++) begin
      vec_t w;
      w = '{4'(f),1'b1,1'b1,4'b1110,1'b1,1'b0,1'b0,1'b1,1'b1,4'(f)};
      step_check($sformatf("load%0d", f), w);
      for (int c = 0; c < 16; c++) begin
        vec_t e;
        e = '{4'b0000,1'b0,1'b0,4'(c),1'b1,1'b0,1'b0,
              ref_decode(4'(c), 4'(f)),1'b1,4'(f)};
        step_check($sformatf("sweep_f%0d_c%0d", f, c), e);
      end
    end

    // Mid-operation reset between edges with a write pending
    step_check("pre_rst_load", '{4'b1111,1'b1,1'b1,4'b1110,1'b1,1'b0,1'b0,1'b1,1'b1,4'b1111});
    flags_in = 4'b0110; s_in = 1'b1; ex_valid_in = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst.flags", flags_out, 4'h0);
    check("mid_rst.carry", {3'b000, carry_out}, 4'h0);
    check("mid_rst.valid", {3'b000, cond_valid_out}, 4'h0);
    check("mid_rst.pass",  {3'b000, cond_pass_out}, 4'h0);
    set_idle();
    #1;
    reset_n = 1'b1;
    step_check("post_rst", '{4'b0000,1'b0,1'b0,4'b0000,1'b1,1'b0,1'b0,1'b0,1'b1,4'b0000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
